// File: rtl/msa_switch_sequencer.sv
// msa_switch_sequencer
// Drives the quadrant-selector analog switches (_D1.._D14) through one
// angle-compare cycle: latch the read-counter angle, open the MSA ladder
// taps while the quadrant sign changes, close the selected tap to settle,
// then close the output gates to sample. Every _D output is active low
// (0 closes the switch) and comes straight from a register.
`timescale 1ns/1ps

module msa_switch_sequencer #(
   parameter int BBM_CYC    = 2,
   parameter int SETTLE_CYC = 8,
   parameter int SAMPLE_CYC = 4,
   parameter int CNT_W      = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic [15:0] angle,
   input  logic        mode,
   input  logic        abort,
   output logic        ack,
   output logic        busy,
   output logic        done,
   output logic        _D1,
   output logic        _D2,
   output logic        _D3,
   output logic        _D4,
   output logic        _D5,
   output logic        _D6,
   output logic        _D7,
   output logic        _D8,
   output logic        _D9,
   output logic        _D10,
   output logic        _D11,
   output logic        _D12,
   output logic        _D13,
   output logic        _D14
);

   // Sequencer states
   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_BREAK  = 3'd1;
   localparam logic [2:0] S_SETTLE = 3'd2;
   localparam logic [2:0] S_SAMPLE = 3'd3;
   localparam logic [2:0] S_DONE   = 3'd4;

   // Phase lengths as counter load values; a phase ends when the count is 1
   localparam logic [CNT_W-1:0] BBM_LD    = CNT_W'(BBM_CYC);
   localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC);
   localparam logic [CNT_W-1:0] SAMPLE_LD = CNT_W'(SAMPLE_CYC);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   logic [2:0]       state;
   logic [CNT_W-1:0] cnt;

   // What the ladder and sign switches currently hold; held_valid=0 means
   // "nothing held", which forces the next request through BREAK
   logic             held_valid;
   logic [1:0]       held_quad;
   logic [1:0]       held_tap;

   // Request fields captured at accept and used by the later phases
   logic [1:0]       lat_tap;
   logic             lat_mode;

   // Switch registers; tap_n[i] drives _D(i+1)
   logic [3:0]       tap_n;
   logic             sign_d5;
   logic             sign_d7;
   logic             gate_d9;
   logic             gate_d10;
   logic             gate_d12;
   logic             gate_d13;
   logic             fb_d11;
   logic             fb_d14;
   logic             spare_open;

   logic             ack_q;
   logic             busy_q;
   logic             done_q;

   // Decode of the incoming request, used only as register inputs
   logic [1:0]       req_quad;
   logic [1:0]       req_tap;
   logic             need_break;
   logic             cnt_last;
   logic             unused_angle_bits;

   // Only one tap of the ladder is ever closed: the addressed one
   function automatic logic [3:0] tap_mask(input logic [1:0] k);
      logic [3:0] m;
      m    = 4'hF;
      m[k] = 1'b0;
      return m;
   endfunction

   // Request decode and "does the ladder need to be re-broken" compare
   always_comb begin
      req_quad   = angle[15:14];
      req_tap    = angle[13:12];
      need_break = !held_valid || (req_quad != held_quad) || (req_tap != held_tap);
      cnt_last   = (cnt == CNT_ONE);
   end

   assign unused_angle_bits = ^angle[11:0];

   // Phase sequencing and all switch registers; abort beats everything
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         cnt        <= '0;
         held_valid <= 1'b0;
         held_quad  <= 2'b00;
         held_tap   <= 2'b00;
         lat_tap    <= 2'b00;
         lat_mode   <= 1'b0;
         tap_n      <= 4'hF;
         sign_d5    <= 1'b1;
         sign_d7    <= 1'b1;
         gate_d9    <= 1'b1;
         gate_d10   <= 1'b1;
         gate_d12   <= 1'b1;
         gate_d13   <= 1'b1;
         fb_d11     <= 1'b1;
         fb_d14     <= 1'b0;
         spare_open <= 1'b1;
         ack_q      <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         ack_q      <= 1'b0;
         done_q     <= 1'b0;
         spare_open <= 1'b1;
         if (abort && (state != S_IDLE)) begin
            state      <= S_IDLE;
            cnt        <= '0;
            busy_q     <= 1'b0;
            held_valid <= 1'b0;
            held_quad  <= 2'b00;
            held_tap   <= 2'b00;
            tap_n      <= 4'hF;
            sign_d5    <= 1'b1;
            sign_d7    <= 1'b1;
            gate_d9    <= 1'b1;
            gate_d10   <= 1'b1;
            gate_d12   <= 1'b1;
            gate_d13   <= 1'b1;
            fb_d11     <= 1'b1;
            fb_d14     <= 1'b0;
         end else begin
            case (state)
               S_IDLE: begin
                  if (req && !abort) begin
                     ack_q      <= 1'b1;
                     busy_q     <= 1'b1;
                     lat_tap    <= req_tap;
                     lat_mode   <= mode;
                     held_valid <= 1'b1;
                     held_quad  <= req_quad;
                     held_tap   <= req_tap;
                     if (need_break) begin
                        // Open every tap and apply the new sign while open
                        state   <= S_BREAK;
                        cnt     <= BBM_LD;
                        tap_n   <= 4'hF;
                        sign_d5 <= req_quad[1];
                        sign_d7 <= req_quad[1] ^ req_quad[0];
                     end else begin
                        // Ladder already loaded with this tap and sign
                        state  <= S_SETTLE;
                        cnt    <= SETTLE_LD;
                        tap_n  <= tap_mask(req_tap);
                        fb_d11 <= mode;
                        fb_d14 <= ~mode;
                     end
                  end
               end
               S_BREAK: begin
                  if (cnt_last) begin
                     state  <= S_SETTLE;
                     cnt    <= SETTLE_LD;
                     tap_n  <= tap_mask(lat_tap);
                     fb_d11 <= lat_mode;
                     fb_d14 <= ~lat_mode;
                  end else begin
                     cnt <= cnt - CNT_ONE;
                  end
               end
               S_SETTLE: begin
                  if (cnt_last) begin
                     state <= S_SAMPLE;
                     cnt   <= SAMPLE_LD;
                     if (lat_mode) begin
                        gate_d10 <= 1'b0;
                        gate_d13 <= 1'b0;
                     end else begin
                        gate_d9  <= 1'b0;
                        gate_d12 <= 1'b0;
                     end
                  end else begin
                     cnt <= cnt - CNT_ONE;
                  end
               end
               S_SAMPLE: begin
                  if (cnt_last) begin
                     state    <= S_DONE;
                     cnt      <= '0;
                     done_q   <= 1'b1;
                     gate_d9  <= 1'b1;
                     gate_d10 <= 1'b1;
                     gate_d12 <= 1'b1;
                     gate_d13 <= 1'b1;
                     fb_d11   <= 1'b1;
                     fb_d14   <= 1'b0;
                  end else begin
                     cnt <= cnt - CNT_ONE;
                  end
               end
               S_DONE: begin
                  state  <= S_IDLE;
                  busy_q <= 1'b0;
               end
               default: begin
                  state  <= S_IDLE;
                  busy_q <= 1'b0;
               end
            endcase
         end
      end
   end

   assign ack  = ack_q;
   assign busy = busy_q;
   assign done = done_q;
   assign _D1  = tap_n[0];
   assign _D2  = tap_n[1];
   assign _D3  = tap_n[2];
   assign _D4  = tap_n[3];
   assign _D5  = sign_d5;
   assign _D6  = spare_open;
   assign _D7  = sign_d7;
   assign _D8  = spare_open;
   assign _D9  = gate_d9;
   assign _D10 = gate_d10;
   assign _D11 = fb_d11;
   assign _D12 = gate_d12;
   assign _D13 = gate_d13;
   assign _D14 = fb_d14;

endmodule
